// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_sequencer_pkg : op encodings, constants and metadata type       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    op_e         op;
    logic        neg_q;
    logic        neg_r;
    logic        special;
    logic [31:0] special_val;
  } meta_t;

  function automatic logic is_signed_op(op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_sequencer_if : request/response handshake bundle                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface div_sequencer_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface
`default_nettype wire

// File: rtl/DividerUnsignedPipelined.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | DividerUnsignedPipelined : restoring 32/32 divider, STAGES deep     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module DividerUnsignedPipelined #(
  parameter int STAGES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int BITS = 32 / STAGES;

  typedef struct packed {
    logic [31:0] dvd;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dsr;
  } div_st_t;

  // One stage retires BITS quotient bits; the 33-bit partial remainder
  // keeps the compare exact for divisors with the top bit set.
  function automatic div_st_t step(div_st_t s);
    div_st_t     n = s;
    logic [32:0] w;
    for (int k = 0; k < BITS; k++) begin
      w     = {n.rem, n.dvd[31]};
      n.dvd = {n.dvd[30:0], 1'b0};
      if (w >= {1'b0, n.dsr}) begin
        w     = w - {1'b0, n.dsr};
        n.quo = {n.quo[30:0], 1'b1};
      end else begin
        n.quo = {n.quo[30:0], 1'b0};
      end
      n.rem = w[31:0];
    end
    return n;
  endfunction

  div_st_t w_in;
  div_st_t r_st [STAGES];

  assign w_in = '{dvd: dividend, rem: 32'd0, quo: 32'd0, dsr: divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_st[i] <= '0;
      end
    end else if (!stall) begin
      r_st[0] <= step(w_in);
      for (int i = 1; i < STAGES; i++) begin
        r_st[i] <= step(r_st[i-1]);
      end
    end
  end

  assign quotient  = r_st[STAGES-1].quo;
  assign remainder = r_st[STAGES-1].rem;

endmodule
`default_nettype wire

// File: rtl/div_meta_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_meta_pipe : per-op metadata shift register, aligned to divider  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module div_meta_pipe
  import div_sequencer_pkg::*;
#(
  parameter int STAGES = 8,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             in_valid,
  input  meta_t            in_meta,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output meta_t            out_meta,
  output logic [TAG_W-1:0] out_tag
);

  logic [STAGES-1:0] r_valid;
  meta_t             r_meta [STAGES];
  logic [TAG_W-1:0]  r_tag  [STAGES];

  // Flush is evaluated after the shift so it wins over both hold and a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_meta[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      if (!hold) begin
        r_valid[0] <= in_valid;
        r_meta[0]  <= in_meta;
        r_tag[0]   <= in_tag;
        for (int i = 1; i < STAGES; i++) begin
          r_valid[i] <= r_valid[i-1];
          r_meta[i]  <= r_meta[i-1];
          r_tag[i]   <= r_tag[i-1];
        end
      end
      if (flush) begin
        r_valid <= '0;
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_meta  = r_meta[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | div_sequencer : signed/unsigned DIV/REM sequencing around the       |
// | shared unsigned divider.  Revision: 1.0                            |
// +--------------------------------------------------------------------+
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int STAGES = 8,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  div_sequencer_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] inflight_cnt
);

  logic             w_hold;
  logic             w_accept;
  logic             w_retire;
  op_e              w_op;
  logic             w_sgn;
  logic [31:0]      w_div_a;
  logic [31:0]      w_div_b;
  meta_t            w_meta_in;
  logic             w_last_valid;
  meta_t            w_last_meta;
  logic [TAG_W-1:0] w_last_tag;
  logic [31:0]      w_quo;
  logic [31:0]      w_rem;
  logic [31:0]      w_result;
  logic [CNT_W-1:0] r_cnt;

  assign w_hold        = bus.resp_valid && !bus.resp_ready;
  assign bus.req_ready = !w_hold && !flush;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_retire      = bus.resp_valid && bus.resp_ready;

  assign w_op    = op_e'(bus.req_op);
  assign w_sgn   = is_signed_op(w_op);
  assign w_div_a = (w_sgn && bus.req_a[31]) ? (~bus.req_a + 32'd1) : bus.req_a;
  assign w_div_b = (w_sgn && bus.req_b[31]) ? (~bus.req_b + 32'd1) : bus.req_b;

  always_comb begin
    w_meta_in       = '0;
    w_meta_in.op    = w_op;
    w_meta_in.neg_q = w_sgn && (bus.req_a[31] ^ bus.req_b[31]);
    w_meta_in.neg_r = w_sgn && bus.req_a[31];
    if (bus.req_b == 32'd0) begin
      w_meta_in.special     = 1'b1;
      w_meta_in.special_val = is_rem_op(w_op) ? bus.req_a : ALL_ONES;
    end else if (w_sgn && bus.req_a == INT_MIN && bus.req_b == ALL_ONES) begin
      w_meta_in.special     = 1'b1;
      w_meta_in.special_val = is_rem_op(w_op) ? 32'd0 : INT_MIN;
    end
  end

  DividerUnsignedPipelined #(
    .STAGES(STAGES)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .stall    (w_hold),
    .dividend (w_div_a),
    .divisor  (w_div_b),
    .quotient (w_quo),
    .remainder(w_rem)
  );

  div_meta_pipe #(
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) u_meta_pipe (
    .clk      (clk),
    .rst      (rst),
    .hold     (w_hold),
    .flush    (flush),
    .in_valid (w_accept),
    .in_meta  (w_meta_in),
    .in_tag   (bus.req_tag),
    .out_valid(w_last_valid),
    .out_meta (w_last_meta),
    .out_tag  (w_last_tag)
  );

  always_comb begin
    w_result = '0;
    if (w_last_meta.special) begin
      w_result = w_last_meta.special_val;
    end else begin
      case (w_last_meta.op)
        OP_DIV, OP_DIVU: w_result = w_last_meta.neg_q ? (~w_quo + 32'd1) : w_quo;
        default:         w_result = w_last_meta.neg_r ? (~w_rem + 32'd1) : w_rem;
      endcase
    end
  end

  // Outputs read as zero whenever no result is present.
  assign bus.resp_valid = w_last_valid;
  assign bus.resp_data  = w_last_valid ? w_result : 32'd0;
  assign bus.resp_tag   = w_last_valid ? w_last_tag : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_cnt <= '0;
    end else if (w_accept && !w_retire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!w_accept && w_retire) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign inflight_cnt = r_cnt;
  assign busy         = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_div_sequencer : directed + random stimulus, queue-based model    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_div_sequencer;

  localparam int STAGES = 8;
  localparam int TAG_W  = 5;
  localparam int CNT_W  = 4;
  localparam logic [31:0] MARK = 32'hBAD0_0BAD;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] inflight_cnt;

  div_sequencer_if #(.TAG_W(TAG_W)) bus ();

  div_sequencer #(
    .STAGES(STAGES),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .busy        (busy),
    .inflight_cnt(inflight_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] got_v, logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got_v, exp_v, $time);
    end
  endtask

  // Arithmetic reference straight from the RISC-V M-extension rules.
  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic is_rem = op[1];
    logic sgn    = !op[0];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return is_rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               stamp;
  } ent_t;

  ent_t        q[$];
  int          adv   = 0;
  logic        chk_en = 1'b0;
  logic [31:0] got [32];
  int          peak  = 0;

  // An accepted op advances one position per cycle without back-pressure
  // and is due once it has advanced STAGES times.
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      logic exp_v;
      logic exp_hold;
      ent_t e;
      exp_v = (q.size() > 0) && ((adv - q[0].stamp) == STAGES);
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_v));
      if (exp_v) begin
        check("resp_data", bus.resp_data, q[0].data);
        check("resp_tag", 32'(bus.resp_tag), 32'(q[0].tag));
      end
      exp_hold = exp_v && !bus.resp_ready;
      check("req_ready", 32'(bus.req_ready), 32'(!exp_hold && !flush));
      check("inflight_cnt", 32'(inflight_cnt), 32'(q.size()));
      check("busy", 32'(busy), 32'(q.size() != 0));
      if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
      if (rst) begin
        q.delete();
      end else begin
        if (exp_v && bus.resp_ready) begin
          got[q[0].tag] = bus.resp_data;
          void'(q.pop_front());
        end
        if (flush) begin
          q.delete();
        end else if (!exp_hold) begin
          if (bus.req_valid) begin
            e.data  = ref_result(bus.req_op, bus.req_a, bus.req_b);
            e.tag   = bus.req_tag;
            e.stamp = adv;
            q.push_back(e);
          end
          adv++;
        end
      end
    end
  end

  task automatic clear_got();
    for (int i = 0; i < 32; i++) got[i] = MARK;
  endtask

  task automatic send(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [TAG_W-1:0] tag);
    logic ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    check("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    logic idle = 1'b0;
    for (int n = 0; n < 200 && !idle; n++) begin
      @(negedge clk);
      idle = (inflight_cnt == '0) && !bus.resp_valid;
    end
    check("drain_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(string tag_name);
    check({tag_name, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag_name, "_resp_data"}, bus.resp_data, 32'd0);
    check({tag_name, "_resp_tag"}, 32'(bus.resp_tag), 32'd0);
    check({tag_name, "_busy"}, 32'(busy), 32'd0);
    check({tag_name, "_inflight"}, 32'(inflight_cnt), 32'd0);
  endtask

  logic [31:0] exp8 [8] = '{32'd0, 32'd3, 32'd6, 32'd10, 32'd13, 32'd16, 32'd20, 32'd23};

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b1;
    clear_got();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Sign fixup and the RISC-V special cases
    send(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1);
    send(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2);
    send(2'b01, 32'd100, 32'd0, 5'd3);
    send(2'b11, 32'd100, 32'd0, 5'd4);
    send(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    wait_idle();
    check("div_neg7_2", got[1], 32'hFFFF_FFFD);
    check("rem_neg7_2", got[2], 32'hFFFF_FFFF);
    check("divu_by0", got[3], 32'hFFFF_FFFF);
    check("remu_by0", got[4], 32'd100);
    check("div_ovf", got[5], 32'h8000_0000);
    check("rem_ovf", got[6], 32'd0);

    // Back-to-back stream at full throughput
    clear_got();
    peak = 0;
    for (int t = 0; t < 8; t++) send(2'b01, 32'(t * 10), 32'd3, 5'(t));
    wait_idle();
    check("peak_inflight", 32'(peak), 32'd8);
    for (int t = 0; t < 8; t++) check("b2b_result", got[t], exp8[t]);

    // Back-pressure beyond the pipe depth
    clear_got();
    bus.resp_ready = 1'b0;
    for (int t = 0; t < 4; t++) send(2'b00, 32'(1000 + t), 32'd7, 5'(t));
    repeat (13) @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    wait_idle();
    check("bp_first", got[0], 32'd142);
    check("bp_last", got[3], 32'd143);

    // Flush with ops in flight and a request in the flush cycle
    clear_got();
    for (int t = 10; t < 14; t++) send(2'b01, 32'd77, 32'd5, 5'(t));
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd2;
    bus.req_tag   = 5'd20;
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("flush_inflight", 32'(inflight_cnt), 32'd0);
    check("flush_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    send(2'b01, 32'd50, 32'd7, 5'd21);
    wait_idle();
    check("post_flush_result", got[21], 32'd7);
    check("flush_cycle_req_dropped", got[20], MARK);
    check("flushed_op_dropped", got[10], MARK);

    // Reset with ops in flight
    clear_got();
    for (int t = 24; t < 27; t++) send(2'b01, 32'd9, 32'd3, 5'(t));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrst");
    repeat (12) @(posedge clk);
    #1;
    check("no_stale_after_rst", got[24], MARK);

    // Random traffic with back-pressure bursts and occasional flushes
    for (int i = 0; i < 600; i++) begin
      bus.req_valid  = ($urandom_range(0, 3) != 0);
      bus.req_op     = 2'($urandom_range(0, 3));
      bus.req_a      = rnd_operand();
      bus.req_b      = rnd_operand();
      bus.req_tag    = 5'($urandom_range(0, 31));
      bus.resp_ready = (i >= 200 && i < 215) ? 1'b0 : ($urandom_range(0, 4) != 0);
      flush          = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    flush          = 1'b0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
